collatz_browser: RTL and testbench
==================================

Name: collatz_browser

Overview:
- Parametrised successor to the lab1 Collatz control logic.
- Sits between board I/O (raw KEY/SW) and the `range` Collatz engine.
- Launches a run from the switch value, waits for done, then browses results with wrap-around, press-and-hold auto-repeat and explicit read-latency tracking.
- Outputs are plain registers; the top level wires them to hex7seg instances.

Parameters:
- N_BITS, 10: width of sw, the launch start value.
- ADDR_BITS, 8: browse offset width.
- RAM_WORDS, 256: number of results; offset range is 0..RAM_WORDS-1, with RAM_WORDS <= 2**ADDR_BITS.
- COUNT_BITS, 16: width of count_i.
- DISP_BITS, 12: width of disp_n; value is truncated modulo 2**DISP_BITS.
- RD_LATENCY, 1: cycles from start_o change until count_i is valid (>=1).
- REPEAT_DELAY, 25000000: held cycles after the first step before auto-repeat begins.
- REPEAT_PERIOD, 4194304: cycles between auto-repeat steps.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous, active-low reset.
- key_n  in  4  raw pushbuttons, active-low, asynchronous. [0]=next, [1]=prev, [2]=home, [3]=launch.
- sw  in  N_BITS  launch value, sampled on a launch press.
- go  out  1  one-cycle launch pulse to range.
- start  out  32  during launch: zero-extended base; otherwise zero-extended offset (read address).
- done  in  1  range completion pulse.
- count  in  COUNT_BITS  result read from range.
- disp_n  out  DISP_BITS  base+offset, truncated.
- disp_count  out  COUNT_BITS  latched count for offset.
- disp_valid  out  1  disp_count matches the current offset.
- busy  out  1  high in LAUNCH and WAIT.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; go=0; start=0; base=0; offset=0; disp_n=0; disp_count=0; disp_valid=0; busy=0; all sync, repeat and latency counters cleared.
- key_n is synchronised by 2 flops. Press = synchronised level low. Press edge = high-to-low of the synchronised level.

FSM:
- IDLE: launch edge -> LAUNCH.
- LAUNCH (exactly 1 cycle): go=1; start=sw zero-extended; base captured from sw; offset=0; disp_valid=0; next state WAIT.
- WAIT: done=1 -> BROWSE, with disp_n=base and a latency count started (address 0).
- BROWSE: handles navigation.
- A launch edge in any state, including WAIT or LAUNCH, restarts at LAUNCH. A launch edge has priority over every other event in the same cycle.
- done outside WAIT is ignored.

Navigation (BROWSE only):
- Priority when several keys are held: home > next > prev. Only the winning key is acted on.
- Winning key changes (new press, or the winner is released): act immediately on the next cycle, then restart the repeat timer.
- Held key: the next step occurs REPEAT_DELAY cycles after the first step, then every REPEAT_PERIOD cycles.
- next: offset=(offset==RAM_WORDS-1)?0:offset+1.
- prev: offset=(offset==0)?RAM_WORDS-1:offset-1.
- home: offset=0, once per press; home does not auto-repeat.
- Any offset change:
  - disp_n <= base+new offset (truncated) in the same cycle as the offset update;
  - disp_valid <= 0;
  - latency count reloads to RD_LATENCY.
- When the latency count reaches 0, disp_count <= count and disp_valid <= 1.
- A step during a pending latency count restarts the count; a stale count is never latched.
- Keys are ignored in IDLE, LAUNCH and WAIT; repeat timers are held at 0 there.

Arithmetic:
- base+offset is computed at max(N_BITS, ADDR_BITS)+1 bits, then truncated to DISP_BITS.

Decomposition:
- Package collatz_pkg holds:
  - state_t enum {IDLE, LAUNCH, WAIT, BROWSE};
  - KEY_NEXT=0, KEY_PREV=1, KEY_HOME=2, KEY_GO=3;
  - nav_t enum {NAV_NONE, NAV_NEXT, NAV_PREV, NAV_HOME}.
- Sub-module key_repeat (parameters REPEAT_DELAY, REPEAT_PERIOD, REPEAT_EN):
  - 2-flop synchroniser, edge detector and hold timer;
  - outputs a one-cycle step pulse.
  - Instantiate 4 copies; the launch and home copies use REPEAT_EN=0.
- The priority arbiter and FSM stay in collatz_browser.

Test Plan:
- All tests use RAM_WORDS=8, REPEAT_DELAY=6, REPEAT_PERIOD=3, RD_LATENCY=1. In the table below, "go high" and similar refer to the go pulse and related outputs.

1. Reset, then sw=27, press key_n[3] -> exactly one go pulse with start=27, busy=1. done after 10 cycles -> BROWSE, disp_n=27, disp_valid=1 one cycle later with disp_count=count at address 0.
2. Tap next 3 times -> offset 1,2,3; disp_n 28,29,30. At offset 7 next -> offset 0, disp_n=27. At offset 0 prev -> offset 7, disp_n=34.
3. Hold next for 20 cycles -> steps at hold cycles 1, 7, 10, 13, 16, 19 (6 steps).
4. Hold next and prev together -> only next steps. Release next while prev is held -> prev steps immediately, then its repeat timer restarts. Hold home with next -> offset 0 once, no repeat.
5. Two steps 1 cycle apart -> disp_valid stays 0 until 1 cycle after the second step; disp_count equals count for the final offset.
6. Launch during WAIT with sw=5 -> new go pulse with start=5. A stale done while in LAUNCH is ignored. Assert reset_n low mid-BROWSE -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/collatz_pkg.sv
// Shared types for the Collatz result browser: FSM states, key indices and navigation actions.
package collatz_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, BROWSE} state_t;

  localparam int unsigned KEY_NEXT = 0;
  localparam int unsigned KEY_PREV = 1;
  localparam int unsigned KEY_HOME = 2;
  localparam int unsigned KEY_GO   = 3;

  typedef enum logic [1:0] {NAV_NONE, NAV_NEXT, NAV_PREV, NAV_HOME} nav_t;

endpackage

// File: rtl/key_repeat.sv
// One pushbutton: 2-flop synchroniser, press-edge detection and press-and-hold auto-repeat.
module key_repeat #(
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 4194304,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic en,
  output logic pressed,
  output logic step
);

  localparam int unsigned MaxCnt = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  logic [1:0]      sync_q;
  logic            active;
  logic            active_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Synchroniser idles at the released level so reset never fakes a press edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], key_n};
      active_q <= active;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed = ~sync_q[1];
  assign active  = pressed & en;

  // cnt_q counts down to the next repeat step; it is held at 0 while inactive.
  always_comb begin
    step  = 1'b0;
    cnt_d = '0;
    if (active && !active_q) begin
      step  = 1'b1;
      cnt_d = CntW'(REPEAT_DELAY - 1);
    end else if (active && REPEAT_EN) begin
      if (cnt_q == '0) begin
        step  = 1'b1;
        cnt_d = CntW'(REPEAT_PERIOD - 1);
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/collatz_browser.sv
// Board-side control for the Collatz range engine: launches a run from sw, waits for done,
// then browses the results with wrap-around, auto-repeat and read-latency tracking.
module collatz_browser
  import collatz_pkg::*;
#(
  parameter int unsigned N_BITS        = 10,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned RAM_WORDS     = 256,
  parameter int unsigned COUNT_BITS    = 16,
  parameter int unsigned DISP_BITS     = 12,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 4194304
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            key_n,
  input  logic [N_BITS-1:0]     sw,
  output logic                  go,
  output logic [31:0]           start,
  input  logic                  done,
  input  logic [COUNT_BITS-1:0] count,
  output logic [DISP_BITS-1:0]  disp_n,
  output logic [COUNT_BITS-1:0] disp_count,
  output logic                  disp_valid,
  output logic                  busy
);

  localparam int unsigned SumW = ((N_BITS > ADDR_BITS) ? N_BITS : ADDR_BITS) + 1;
  localparam int unsigned LatW = $clog2(RD_LATENCY + 1);

  state_t state_q, state_d;
  nav_t   winner, nav;

  logic [3:0] key_pressed, key_en, key_step;
  logic       launch;
  logic       unused_go_pressed;

  logic [N_BITS-1:0]     base_q, base_d;
  logic [ADDR_BITS-1:0]  offset_q, offset_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic                  go_d, busy_d, disp_valid_d;
  logic [31:0]           start_d;
  logic [DISP_BITS-1:0]  disp_n_d;
  logic [COUNT_BITS-1:0] disp_count_d;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN    (bit'(i == KEY_NEXT || i == KEY_PREV))
    ) u_key (
      .clk    (clk),
      .reset_n(reset_n),
      .key_n  (key_n[i]),
      .en     (key_en[i]),
      .pressed(key_pressed[i]),
      .step   (key_step[i])
    );
  end

  assign unused_go_pressed = key_pressed[KEY_GO];
  assign launch            = key_step[KEY_GO];

  // Only the winning key is enabled, so a change of winner looks like a fresh press to it.
  always_comb begin
    winner = NAV_NONE;
    if (key_pressed[KEY_HOME])      winner = NAV_HOME;
    else if (key_pressed[KEY_NEXT]) winner = NAV_NEXT;
    else if (key_pressed[KEY_PREV]) winner = NAV_PREV;

    key_en         = '0;
    key_en[KEY_GO] = 1'b1;
    if (state_q == BROWSE) begin
      unique case (winner)
        NAV_NEXT: key_en[KEY_NEXT] = 1'b1;
        NAV_PREV: key_en[KEY_PREV] = 1'b1;
        NAV_HOME: key_en[KEY_HOME] = 1'b1;
        NAV_NONE: ;
      endcase
    end

    nav = NAV_NONE;
    if (key_step[KEY_HOME])      nav = NAV_HOME;
    else if (key_step[KEY_NEXT]) nav = NAV_NEXT;
    else if (key_step[KEY_PREV]) nav = NAV_PREV;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (launch) begin
      state_d = LAUNCH;
    end else begin
      unique case (state_q)
        IDLE:    ;
        LAUNCH:  state_d = WAIT;
        WAIT:    if (done) state_d = BROWSE;
        BROWSE:  ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    base_d       = base_q;
    offset_d     = offset_q;
    lat_d        = lat_q;
    disp_n_d     = disp_n;
    disp_count_d = disp_count;
    disp_valid_d = disp_valid;

    if (launch) begin
      base_d       = sw;
      offset_d     = '0;
      lat_d        = '0;
      disp_valid_d = 1'b0;
    end else if (state_q == WAIT && done) begin
      disp_n_d     = DISP_BITS'(SumW'(base_q) + SumW'(offset_q));
      lat_d        = LatW'(RD_LATENCY);
      disp_valid_d = 1'b0;
    end else if (state_q == BROWSE) begin
      if (nav != NAV_NONE) begin
        unique case (nav)
          NAV_NEXT: offset_d = (offset_q == ADDR_BITS'(RAM_WORDS - 1)) ? '0
                                                                       : offset_q + ADDR_BITS'(1);
          NAV_PREV: offset_d = (offset_q == '0) ? ADDR_BITS'(RAM_WORDS - 1)
                                                : offset_q - ADDR_BITS'(1);
          NAV_HOME: offset_d = '0;
          default:  offset_d = offset_q;
        endcase
        disp_n_d     = DISP_BITS'(SumW'(base_q) + SumW'(offset_d));
        lat_d        = LatW'(RD_LATENCY);
        disp_valid_d = 1'b0;
      end else if (lat_q != '0) begin
        // A step always reloads the count, so the latch below only sees the current address.
        lat_d = lat_q - LatW'(1);
        if (lat_q == LatW'(1)) begin
          disp_count_d = count;
          disp_valid_d = 1'b1;
        end
      end
    end

    go_d    = (state_d == LAUNCH);
    busy_d  = (state_d == LAUNCH) || (state_d == WAIT);
    start_d = (state_d == LAUNCH) ? 32'(base_d) : 32'(offset_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      offset_q   <= '0;
      lat_q      <= '0;
      go         <= 1'b0;
      busy       <= 1'b0;
      start      <= '0;
      disp_n     <= '0;
      disp_count <= '0;
      disp_valid <= 1'b0;
    end else begin
      base_q     <= base_d;
      offset_q   <= offset_d;
      lat_q      <= lat_d;
      go         <= go_d;
      busy       <= busy_d;
      start      <= start_d;
      disp_n     <= disp_n_d;
      disp_count <= disp_count_d;
      disp_valid <= disp_valid_d;
    end
  end

endmodule

// File: tb/tb_collatz_browser.sv
// Self-checking bench for collatz_browser: directed scenarios plus random key/done/launch
// traffic, checked every cycle against a behavioural model of the browser.
module tb_collatz_browser;

  localparam int N_BITS = 10;
  localparam int ADDR_BITS = 4;
  localparam int RAM_WORDS = 8;
  localparam int COUNT_BITS = 16;
  localparam int DISP_BITS = 8;
  localparam int RD_LATENCY = 1;
  localparam int DLY = 6;
  localparam int PER = 3;

  logic                  clk;
  logic                  reset_n;
  logic [3:0]            key_n;
  logic [N_BITS-1:0]     sw;
  logic                  go;
  logic [31:0]           start;
  logic                  done;
  logic [COUNT_BITS-1:0] count;
  logic [DISP_BITS-1:0]  disp_n;
  logic [COUNT_BITS-1:0] disp_count;
  logic                  disp_valid;
  logic                  busy;

  collatz_browser #(
    .N_BITS(N_BITS), .ADDR_BITS(ADDR_BITS), .RAM_WORDS(RAM_WORDS), .COUNT_BITS(COUNT_BITS),
    .DISP_BITS(DISP_BITS), .RD_LATENCY(RD_LATENCY), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .sw(sw), .go(go), .start(start),
    .done(done), .count(count), .disp_n(disp_n), .disp_count(disp_count),
    .disp_valid(disp_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [COUNT_BITS-1:0] mem [RAM_WORDS];
  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;
  int go_pulses = 0;
  int go_start = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Results RAM stand-in: the read for the current address settles within the cycle.
  initial forever begin
    @(negedge clk);
    count = (start < 32'(RAM_WORDS)) ? mem[start[2:0]] : 16'hffff;
  end

  // Behavioural model. States: 0 idle, 1 launch, 2 wait, 3 browse.
  // Winners: 0 none, 1 next, 2 prev, 3 home.
  int m_st, m_base, m_off, m_pend, m_go, m_start, m_dn, m_dc, m_dv, m_busy, m_pw, m_age;
  logic [3:0] m_s1, m_s2, m_prev;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_st = 0; m_base = 0; m_off = 0; m_pend = 0; m_go = 0; m_start = 0;
      m_dn = 0; m_dc = 0; m_dv = 0; m_busy = 0; m_pw = 0; m_age = 0;
      m_s1 = 4'hf; m_s2 = 4'hf; m_prev = 4'hf;
    end else begin
      logic [3:0] lvl;
      bit launch, step;
      int w;
      lvl = m_s2;
      launch = m_prev[3] && !lvl[3];
      w = 0;
      if (m_st == 3) begin
        if (!lvl[2]) w = 3;
        else if (!lvl[0]) w = 1;
        else if (!lvl[1]) w = 2;
      end
      step = 0;
      if (w != m_pw) begin
        m_age = 0;
        step = (w != 0);
      end else if (w != 0) begin
        m_age++;
        step = (w != 3) && (m_age == DLY || (m_age > DLY && (m_age - DLY) % PER == 0));
      end
      m_pw = w;
      if (launch) begin
        m_st = 1; m_base = int'(sw); m_off = 0; m_dv = 0; m_pend = 0;
      end else begin
        case (m_st)
          1: m_st = 2;
          2: if (done) begin
            m_st = 3; m_dn = m_base % (1 << DISP_BITS); m_pend = RD_LATENCY; m_dv = 0;
          end
          3: begin
            if (step) begin
              if (w == 1) m_off = (m_off + 1) % RAM_WORDS;
              else if (w == 2) m_off = (m_off + RAM_WORDS - 1) % RAM_WORDS;
              else m_off = 0;
              m_dn = (m_base + m_off) % (1 << DISP_BITS);
              m_dv = 0;
              m_pend = RD_LATENCY;
            end else if (m_pend > 0) begin
              m_pend--;
              if (m_pend == 0) begin
                m_dc = int'(count);
                m_dv = 1;
              end
            end
          end
          default: ;
        endcase
      end
      m_go = (m_st == 1) ? 1 : 0;
      m_busy = (m_st == 1 || m_st == 2) ? 1 : 0;
      m_start = (m_st == 1) ? m_base : m_off;
      m_prev = lvl; m_s2 = m_s1; m_s1 = key_n;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      if (go) begin
        go_pulses++;
        go_start = int'(start);
      end
      chk("go", 64'(go), 64'(m_go));
      chk("start", 64'(start), 64'(m_start));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("disp_n", 64'(disp_n), 64'(m_dn));
      chk("disp_valid", 64'(disp_valid), 64'(m_dv));
      chk("disp_count", 64'(disp_count), 64'(m_dc));
    end
  end

  task automatic tap(input int k);
    key_n[k] = 1'b0;
    tick(1);
    key_n[k] = 1'b1;
    tick(3);
  endtask

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) mem[i] = 16'($urandom);
    reset_n = 1'b0; key_n = 4'hf; sw = '0; done = 1'b0; count = '0;
    tick(2);
    cmp_en = 1;
    chk("rst_go", 64'(go), 0);
    chk("rst_start", 64'(start), 0);
    chk("rst_disp_n", 64'(disp_n), 0);
    chk("rst_valid", 64'(disp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    reset_n = 1'b1;
    tick(2);

    // 1: launch with 27, done 10 cycles later
    sw = 10'd27;
    key_n[3] = 1'b0;
    tick(3);
    key_n[3] = 1'b1;
    tick(3);
    chk("t1_go_pulses", 64'(go_pulses), 1);
    chk("t1_go_start", 64'(go_start), 27);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_model_base", 64'(m_base), 27);
    tick(7);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("t1_disp_n", 64'(disp_n), 27);
    chk("t1_busy_off", 64'(busy), 0);
    tick(1);
    chk("t1_valid", 64'(disp_valid), 1);
    chk("t1_count", 64'(disp_count), 64'(mem[0]));

    // 2: taps and wrap-around
    for (int i = 1; i <= 3; i++) begin
      tap(0);
      chk("t2_next", 64'(disp_n), 64'(27 + i));
    end
    for (int i = 0; i < 4; i++) tap(0);
    chk("t2_at7", 64'(disp_n), 34);
    tap(0);
    chk("t2_wrap_next", 64'(disp_n), 27);
    tap(1);
    chk("t2_wrap_prev", 64'(disp_n), 34);

    // 3: hold next 20 cycles -> 6 steps from offset 0
    tap(2);
    chk("t3_home", 64'(disp_n), 27);
    key_n[0] = 1'b0;
    tick(20);
    key_n[0] = 1'b1;
    tick(5);
    chk("t3_hold", 64'(disp_n), 33);
    chk("t3_model_off", 64'(m_off), 6);

    // 4: priority next > prev, hand-over to prev, home over next
    tap(2);
    key_n[1:0] = 2'b00;
    tick(4);
    chk("t4_next_wins", 64'(disp_n), 28);
    key_n[0] = 1'b1;
    tick(4);
    chk("t4_prev_takes", 64'(disp_n), 27);
    key_n[1] = 1'b1;
    tick(4);
    key_n[0] = 1'b0;
    tick(3);
    key_n[2] = 1'b0;
    tick(15);
    key_n[2] = 1'b1;
    key_n[0] = 1'b1;
    tick(4);
    chk("t4_home_once", 64'(disp_n), 27);

    // 5: two steps on consecutive cycles (offset 2 -> 3 -> 2)
    tap(0);
    tap(0);
    key_n[0] = 1'b0;
    tick(1);
    key_n[0] = 1'b1;
    key_n[1] = 1'b0;
    tick(1);
    key_n[1] = 1'b1;
    tick(1);
    chk("t5_valid_step1", 64'(disp_valid), 0);
    tick(1);
    chk("t5_valid_step2", 64'(disp_valid), 0);
    chk("t5_disp_n", 64'(disp_n), 29);
    tick(1);
    chk("t5_valid_late", 64'(disp_valid), 1);
    chk("t5_count", 64'(disp_count), 64'(mem[2]));

    // 6: relaunch during WAIT, stale done in LAUNCH, async reset mid-BROWSE
    sw = 10'd100;
    key_n[3] = 1'b0;
    tick(2);
    key_n[3] = 1'b1;
    tick(6);
    chk("t6_wait", 64'(busy), 1);
    sw = 10'd5;
    key_n[3] = 1'b0;
    for (int i = 0; i < 8 && go !== 1'b1; i++) tick(1);
    chk("t6_go_seen", 64'(go), 1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    key_n[3] = 1'b1;
    chk("t6_stale_done_busy", 64'(busy), 1);
    chk("t6_go_pulses", 64'(go_pulses), 3);
    chk("t6_go_start", 64'(go_start), 5);
    tick(3);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("t6_disp_n", 64'(disp_n), 5);
    tap(0);
    chk("t6_next", 64'(disp_n), 6);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_arst_go", 64'(go), 0);
    chk("t6_arst_start", 64'(start), 0);
    chk("t6_arst_disp_n", 64'(disp_n), 0);
    chk("t6_arst_count", 64'(disp_count), 0);
    chk("t6_arst_valid", 64'(disp_valid), 0);
    chk("t6_arst_busy", 64'(busy), 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Random traffic, checked cycle by cycle against the model
    repeat (300) begin
      int r;
      logic [2:0] kn;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        sw = 10'($urandom_range(0, 1023));
        key_n[3] = 1'b0;
        tick($urandom_range(1, 3));
        key_n[3] = 1'b1;
      end else if (r < 22) begin
        done = 1'b1;
        tick(1);
        done = 1'b0;
      end else begin
        case ($urandom_range(0, 6))
          0: kn = 3'b110;
          1: kn = 3'b101;
          2: kn = 3'b011;
          3: kn = 3'b100;
          4: kn = 3'b010;
          5: kn = 3'b111;
          default: kn = 3'($urandom);
        endcase
        key_n[2:0] = kn;
        tick($urandom_range(1, 25));
      end
    end
    key_n = 4'hf;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
